mp3_sdi_sender: RTL

- Transmit end of the 256-bit chunk handshake: accepts one 256-bit chunk from the MP3 data allocator (DATA_VALID / SENDER_IS_SENDING) and serialises it to the VS10xx decoder's SDI port (XDCS, SCLK, SI).
- Gated by the decoder's DREQ.
- One chunk is 32 bytes, which matches the decoder's guaranteed 32-byte FIFO space per DREQ.

---
 rtl/mp3_sdi_sender.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mp3_sdi_sender.sv
// -----------------------------------------------------------------------------
// mp3_sdi_sender
//
// Purpose:
//   Transmit end of the chunk handshake between the MP3 data allocator and a
//   VS10xx decoder. It accepts one DATA_WIDTH-bit chunk (DATA_VALID /
//   SENDER_IS_SENDING), waits for the decoder's DREQ, then serialises the chunk
//   MSB first on the SDI port (XDCS, SCLK, SI). A 256-bit chunk is 32 bytes,
//   which is exactly the FIFO space the decoder guarantees per DREQ.
//
// Parameters:
//   CLK_DIV    : CLK cycles per SCLK half-period (>= 2).
//   DATA_WIDTH : chunk width in bits (multiple of 8).
//
// Ports:
//   CLK               in   system clock, rising edge
//   RST               in   synchronous active-high reset
//   DATA_VALID        in   chunk on DATA_TO_SEND is valid
//   DATA_TO_SEND      in   chunk, bit [DATA_WIDTH-1] goes out first
//   DREQ              in   decoder can take at least 32 bytes
//   SENDER_IS_SENDING out  busy, from acceptance until the chunk is fully sent
//   XDCS              out  SDI chip select, active low
//   SCLK              out  serial clock, idles low
//   SI                out  serial data, MSB first
//   fsm_state         out  current FSM state (debug visibility)
//
// Handshake: a chunk is taken when DATA_VALID is sampled high in IDLE while the
// sender is armed. Arming requires DATA_VALID to have been sampled low since
// the previous acceptance, so a DATA_VALID left high across the busy fall
// cannot cause the same chunk to be sent twice.
//
// Optional feature (macro MP3_SDI_BYTE_CS_EN): XDCS is released for
// 2*CLK_DIV cycles between bytes, with SCLK low. Without the macro XDCS stays
// low for the whole chunk.
// -----------------------------------------------------------------------------
module mp3_sdi_sender #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DATA_VALID,
  input  logic [DATA_WIDTH-1:0] DATA_TO_SEND,
  input  logic                  DREQ,
  output logic                  SENDER_IS_SENDING,
  output logic                  XDCS,
  output logic                  SCLK,
  output logic                  SI,
  output logic [2:0]            fsm_state
);

  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DREQ = 3'd1,
    SHIFT     = 3'd2,
    TAIL      = 3'd3,
    GUARD     = 3'd4,
    BYTE_GAP  = 3'd5
  } state_t;

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_d;
  logic [DIV_W-1:0]      div_cnt, div_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  xdcs_q, xdcs_d;
  logic                  si_q, si_d;
  logic                  busy_q, busy_d;
  logic                  armed, armed_d;
  logic                  div_last;
  logic                  last_bit;

`ifdef MP3_SDI_BYTE_CS_EN
  // The gap between bytes is two half-periods long; this flag marks the
  // second one so the divider counter can keep its normal width.
  logic gap_second, gap_second_d;
`endif

  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    div_cnt_d = div_cnt;
    sclk_d    = sclk_q;
    xdcs_d    = xdcs_q;
    si_d      = si_q;
    busy_d    = busy_q;
    armed_d   = armed;
`ifdef MP3_SDI_BYTE_CS_EN
    gap_second_d = gap_second;
`endif

    // Re-arm on any cycle where the allocator has dropped DATA_VALID.
    if (!DATA_VALID) begin
      armed_d = 1'b1;
    end

    case (state)
      IDLE: begin
        if (DATA_VALID && armed) begin
          shreg_d   = DATA_TO_SEND;
          busy_d    = 1'b1;
          armed_d   = 1'b0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = WAIT_DREQ;
        end
      end

      WAIT_DREQ: begin
        // DREQ is looked at only here; once shifting starts the 32-byte
        // guarantee covers the whole chunk.
        if (DREQ) begin
          xdcs_d    = 1'b0;
          sclk_d    = 1'b0;
          si_d      = shreg[DATA_WIDTH-1];
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (!div_last) begin
          div_cnt_d = div_cnt + 1'b1;
        end else begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            // End of the low half: rising edge, decoder samples SI.
            sclk_d = 1'b1;
          end else begin
            // End of the high half: falling edge closes this bit.
            sclk_d = 1'b0;
            if (last_bit) begin
              bit_cnt_d = '0;
              state_d   = TAIL;
            end
`ifdef MP3_SDI_BYTE_CS_EN
            else if (bit_cnt[2:0] == 3'd7) begin
              // Byte boundary: release chip select. The bit counter is kept
              // across the gap since it tracks progress through the chunk.
              bit_cnt_d    = bit_cnt + 1'b1;
              xdcs_d       = 1'b1;
              gap_second_d = 1'b0;
              state_d      = BYTE_GAP;
            end
`endif
            else begin
              bit_cnt_d = bit_cnt + 1'b1;
              shreg_d   = {shreg[DATA_WIDTH-2:0], 1'b0};
              si_d      = shreg[DATA_WIDTH-2];
            end
          end
        end
      end

`ifdef MP3_SDI_BYTE_CS_EN
      BYTE_GAP: begin
        if (!div_last) begin
          div_cnt_d = div_cnt + 1'b1;
        end else begin
          div_cnt_d = '0;
          if (!gap_second) begin
            gap_second_d = 1'b1;
          end else begin
            // Reselect and present the next byte's MSB together.
            gap_second_d = 1'b0;
            xdcs_d       = 1'b0;
            shreg_d      = {shreg[DATA_WIDTH-2:0], 1'b0};
            si_d         = shreg[DATA_WIDTH-2];
            state_d      = SHIFT;
          end
        end
      end
`endif

      TAIL: begin
        if (!div_last) begin
          div_cnt_d = div_cnt + 1'b1;
        end else begin
          div_cnt_d = '0;
          xdcs_d    = 1'b1;
          state_d   = GUARD;
        end
      end

      GUARD: begin
        if (!div_last) begin
          div_cnt_d = div_cnt + 1'b1;
        end else begin
          div_cnt_d = '0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        div_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sclk_q  <= 1'b0;
      xdcs_q  <= 1'b1;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      armed   <= 1'b1;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      div_cnt <= div_cnt_d;
      sclk_q  <= sclk_d;
      xdcs_q  <= xdcs_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      armed   <= armed_d;
    end
  end

`ifdef MP3_SDI_BYTE_CS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      gap_second <= 1'b0;
    end else begin
      gap_second <= gap_second_d;
    end
  end
`endif

  assign SENDER_IS_SENDING = busy_q;
  assign XDCS              = xdcs_q;
  assign SCLK              = sclk_q;
  assign SI                = si_q;
  assign fsm_state         = state;

endmodule
